// File: rtl/alu_pipe_exec_if.sv
// Handshake bundle for alu_pipe_exec: instruction issue, host register writes
// and the result stream, with master (driver) and slave (unit) views.
interface alu_pipe_exec_if #(
    parameter int WIDTH = 8,
    parameter int NREG  = 8
);
    localparam int AW = $clog2(NREG);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [AW-1:0]    in_rd;
    logic [AW-1:0]    in_rs;
    logic [AW-1:0]    in_rt;

    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [WIDTH-1:0] cfg_data;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW-1:0]    out_rd;
    logic             out_zero;
    logic             out_ovf;

    modport master (
        output in_valid, in_op, in_rd, in_rs, in_rt,
        output cfg_we, cfg_addr, cfg_data,
        output out_ready,
        input  in_ready,
        input  out_valid, out_data, out_rd, out_zero, out_ovf
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs, in_rt,
        input  cfg_we, cfg_addr, cfg_data,
        input  out_ready,
        output in_ready,
        output out_valid, out_data, out_rd, out_zero, out_ovf
    );
endinterface

// File: rtl/alu_pipe_exec.sv
// Two-stage decode/execute unit with an NREG x WIDTH register file and writeback.
// Optional macro ALU_PIPE_SEVSEG_EN adds a one-digit seven-segment view of results.
module alu_pipe_exec #(
    parameter int WIDTH = 8,
    parameter int NREG  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_pipe_exec_if.slave    bus
`ifdef ALU_PIPE_SEVSEG_EN
    ,
    output logic [6:0]        seg,
    output logic [3:0]        an
`endif
);
    localparam int AW = $clog2(NREG);

    localparam logic [2:0] OP_SUB = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_SRA = 3'd4;
    localparam logic [2:0] OP_ROL = 3'd5;
    localparam logic [2:0] OP_LT  = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [AW-1:0]    s1_rd_q, s1_rd_d;
    logic [AW-1:0]    s1_rs_q, s1_rs_d;
    logic [AW-1:0]    s1_rt_q, s1_rt_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    logic [AW-1:0]    s2_rd_q, s2_rd_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_ovf_q, s2_ovf_d;

    logic             s1_adv;
    logic             accept;
    logic [WIDTH-1:0] op_a, op_b, alu_res;
    logic             alu_ovf;

    // A host write owns the register file for its cycle, so S1 waits.
    assign s1_adv       = s1_valid_q && !bus.cfg_we && (!s2_valid_q || bus.out_ready);
    assign bus.in_ready = !s1_valid_q || s1_adv;
    assign accept       = bus.in_valid && bus.in_ready;

    // Operands come from the pre-edge register state, so rd == rs/rt reads the old value.
    assign op_a = regs_q[s1_rs_q];
    assign op_b = regs_q[s1_rt_q];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_res = '0;
        alu_ovf = 1'b0;
        case (s1_op_q)
            OP_SUB: begin
                alu_res = op_a - op_b;
                alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_ADD: begin
                alu_res = op_a + op_b;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_OR:  alu_res = op_a | op_b;
            OP_AND: alu_res = op_a & op_b;
            OP_SRA: alu_res = {op_b[WIDTH-1], op_b[WIDTH-1:1]};
            OP_ROL: alu_res = {op_a[WIDTH-2:0], op_a[WIDTH-1]};
            OP_LT:  alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            OP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, (op_a == op_b)};
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (bus.cfg_we) begin
            regs_d[bus.cfg_addr] = bus.cfg_data;
        end else if (s1_adv) begin
            regs_d[s1_rd_q] = alu_res;
        end

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_rd_d    = s1_rd_q;
        s1_rs_d    = s1_rs_q;
        s1_rt_d    = s1_rt_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = bus.in_op;
            s1_rd_d    = bus.in_rd;
            s1_rs_d    = bus.in_rs;
            s1_rt_d    = bus.in_rt;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // Result fields only change on a new result, so they hold while idle or stalled.
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_rd_d    = s2_rd_q;
        s2_zero_d  = s2_zero_q;
        s2_ovf_d   = s2_ovf_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_data_d  = alu_res;
            s2_rd_d    = s1_rd_q;
            s2_zero_d  = (alu_res == '0);
            s2_ovf_d   = alu_ovf;
        end else if (s2_valid_q && bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is architectural state that must read 0 after reset,
            // so it is built from resettable flops rather than an inferred RAM.
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_rd_q    <= '0;
            s1_rs_q    <= '0;
            s1_rt_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_rd_q    <= '0;
            s2_zero_q  <= 1'b0;
            s2_ovf_q   <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples
            // pre-edge values regardless of statement order.
            regs_q     <= regs_d;
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_rd_q    <= s1_rd_d;
            s1_rs_q    <= s1_rs_d;
            s1_rt_q    <= s1_rt_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_rd_q    <= s2_rd_d;
            s2_zero_q  <= s2_zero_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_rd    = s2_rd_q;
    assign bus.out_zero  = s2_zero_q;
    assign bus.out_ovf   = s2_ovf_q;

`ifdef ALU_PIPE_SEVSEG_EN
    logic [3:0] disp_q, disp_d;

    always_comb begin
        disp_d = disp_q;
        if (s2_valid_q && bus.out_ready) begin
            disp_d = s2_data_q[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
        end else begin
            disp_q <= disp_d;
        end
    end

    // Segment patterns are written active-high (gfedcba) and inverted for the display.
    always_comb begin
        seg = ~7'h3F;
        case (disp_q)
            4'h0: seg = ~7'h3F;
            4'h1: seg = ~7'h06;
            4'h2: seg = ~7'h5B;
            4'h3: seg = ~7'h4F;
            4'h4: seg = ~7'h66;
            4'h5: seg = ~7'h6D;
            4'h6: seg = ~7'h7D;
            4'h7: seg = ~7'h07;
            4'h8: seg = ~7'h7F;
            4'h9: seg = ~7'h6F;
            4'hA: seg = ~7'h77;
            4'hB: seg = ~7'h7C;
            4'hC: seg = ~7'h39;
            4'hD: seg = ~7'h5E;
            4'hE: seg = ~7'h79;
            4'hF: seg = ~7'h71;
        endcase
    end

    assign an = 4'b1110;
`endif
endmodule

// File: tb/tb_alu_pipe_exec.sv
// Directed bench for alu_pipe_exec: an opcode/flag vector table plus hand-written
// sequences for reset, dependency, backpressure and host-write conflicts.
module tb_alu_pipe_exec;
    localparam int WIDTH = 8;
    localparam int NREG  = 8;

    localparam logic [2:0] SUB = 3'd0, ADD = 3'd1, OR_ = 3'd2, AND_ = 3'd3;
    localparam logic [2:0] SRA = 3'd4, ROL = 3'd5, LT = 3'd6, EQ = 3'd7;

    logic clk;
    logic rst_n;

    alu_pipe_exec_if #(.WIDTH(WIDTH), .NREG(NREG)) bus ();

    alu_pipe_exec #(.WIDTH(WIDTH), .NREG(NREG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_data;
        logic       exp_zero;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [13];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [7:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic drive_instr(input logic [2:0] op, input logic [2:0] rd,
                               input logic [2:0] rs, input logic [2:0] rt);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
    endtask

    // Present one instruction and hold it until accepted (bounded wait).
    task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [2:0] rt);
        int waited;
        drive_instr(op, rd, rs, rt);
        #1;
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) check("issue_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic exec_one(input string name, input logic [2:0] op, input logic [2:0] rd,
                            input logic [2:0] rs, input logic [2:0] rt,
                            input logic [7:0] exp_data, input logic exp_zero, input logic exp_ovf);
        issue(op, rd, rs, rt);
        tick();
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_data"},  32'(bus.out_data),  32'(exp_data));
        check({name, "_rd"},    32'(bus.out_rd),    32'(rd));
        check({name, "_zero"},  32'(bus.out_zero),  32'(exp_zero));
        check({name, "_ovf"},   32'(bus.out_ovf),   32'(exp_ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        //         op    rd    rs    rt    a      b      data   z     v
        vecs[0]  = '{ADD,  3'd3, 3'd1, 3'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[1]  = '{SUB,  3'd3, 3'd1, 3'd2, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
        vecs[2]  = '{SUB,  3'd3, 3'd3, 3'd3, 8'h37, 8'h37, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{LT,   3'd3, 3'd1, 3'd2, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0};
        vecs[4]  = '{LT,   3'd3, 3'd1, 3'd2, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{EQ,   3'd3, 3'd1, 3'd2, 8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0};
        vecs[6]  = '{EQ,   3'd3, 3'd1, 3'd2, 8'h5A, 8'h5B, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{SRA,  3'd5, 3'd1, 3'd2, 8'h81, 8'h90, 8'hC8, 1'b0, 1'b0};
        vecs[8]  = '{ROL,  3'd6, 3'd1, 3'd2, 8'h81, 8'h90, 8'h03, 1'b0, 1'b0};
        vecs[9]  = '{OR_,  3'd7, 3'd1, 3'd2, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
        vecs[10] = '{AND_, 3'd0, 3'd1, 3'd2, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{SUB,  3'd4, 3'd1, 3'd2, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[12] = '{ADD,  3'd4, 3'd1, 3'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_rd     = '0;
        bus.in_rs     = '0;
        bus.in_rt     = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.out_ready = 1'b1;

        // Power-on reset
        #12;
        check("por_out_valid", 32'(bus.out_valid), 32'd0);
        check("por_out_data",  32'(bus.out_data),  32'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check("por_in_ready", 32'(bus.in_ready), 32'd1);

        // Dependent back-to-back: SUB then ADD consuming its result
        cfg_write(3'd1, 8'h05);
        cfg_write(3'd2, 8'h03);
        drive_instr(SUB, 3'd3, 3'd1, 3'd2);
        #1;
        check("b2b_ready0", 32'(bus.in_ready), 32'd1);
        tick();
        drive_instr(ADD, 3'd4, 3'd3, 3'd1);
        #1;
        check("b2b_ready1", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("b2b_v0",    32'(bus.out_valid), 32'd1);
        check("b2b_data0", 32'(bus.out_data),  32'h02);
        check("b2b_rd0",   32'(bus.out_rd),    32'd3);
        tick();
        check("b2b_v1",    32'(bus.out_valid), 32'd1);
        check("b2b_data1", 32'(bus.out_data),  32'h07);
        check("b2b_rd1",   32'(bus.out_rd),    32'd4);
        tick();
        check("b2b_drain", 32'(bus.out_valid), 32'd0);

        // Opcode and flag table
        for (int i = 0; i < 13; i++) begin
            cfg_write(vecs[i].rs, vecs[i].a);
            if (vecs[i].rt != vecs[i].rs) cfg_write(vecs[i].rt, vecs[i].b);
            exec_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt,
                     vecs[i].exp_data, vecs[i].exp_zero, vecs[i].exp_ovf);
        end

        // Backpressure: three instructions against a stalled consumer
        cfg_write(3'd1, 8'h10);
        cfg_write(3'd2, 8'h01);
        tick();
        bus.out_ready = 1'b0;
        drive_instr(ADD, 3'd3, 3'd1, 3'd2);
        tick();
        drive_instr(SUB, 3'd4, 3'd1, 3'd2);
        tick();
        drive_instr(AND_, 3'd5, 3'd1, 3'd1);
        #1;
        check("bp_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_data0",     32'(bus.out_data), 32'h11);
        tick();
        tick();
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        check("bp_hold_data",  32'(bus.out_data),  32'h11);
        check("bp_hold_rd",    32'(bus.out_rd),    32'd3);
        check("bp_hold_ready", 32'(bus.in_ready),  32'd0);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_v1",    32'(bus.out_valid), 32'd1);
        check("bp_data1", 32'(bus.out_data),  32'h0F);
        check("bp_rd1",   32'(bus.out_rd),    32'd4);
        tick();
        check("bp_v2",    32'(bus.out_valid), 32'd1);
        check("bp_data2", 32'(bus.out_data),  32'h10);
        check("bp_rd2",   32'(bus.out_rd),    32'd5);
        tick();
        check("bp_drain", 32'(bus.out_valid), 32'd0);

        // Host write to an operand while S1 holds the instruction
        cfg_write(3'd1, 8'h05);
        cfg_write(3'd2, 8'h03);
        drive_instr(ADD, 3'd3, 3'd1, 3'd2);
        tick();
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd1;
        bus.cfg_data = 8'h20;
        #1;
        check("cfg_stall_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.cfg_we = 1'b0;
        check("cfg_stall_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("cfg_exec_valid", 32'(bus.out_valid), 32'd1);
        check("cfg_exec_data",  32'(bus.out_data),  32'h23);
        check("cfg_exec_rd",    32'(bus.out_rd),    32'd3);
        tick();
        cfg_write(3'd3, 8'h44);
        exec_one("last_write", OR_, 3'd7, 3'd3, 3'd3, 8'h44, 1'b0, 1'b0);

        // Reset with a result held in S2: outputs and registers cleared, no writeback
        cfg_write(3'd1, 8'h11);
        bus.out_ready = 1'b0;
        issue(ADD, 3'd4, 3'd1, 3'd1);
        tick();
        check("mid_pre_data", 32'(bus.out_data), 32'h22);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data",  32'(bus.out_data),  32'h00);
        check("mid_rst_rd",    32'(bus.out_rd),    32'd0);
        check("mid_rst_flags", 32'({bus.out_zero, bus.out_ovf}), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("mid_rel_ready", 32'(bus.in_ready),  32'd1);
        check("mid_rel_valid", 32'(bus.out_valid), 32'd0);
        exec_one("mid_r4_cleared", OR_, 3'd5, 3'd4, 3'd4, 8'h00, 1'b1, 1'b0);
        exec_one("mid_r1_cleared", OR_, 3'd6, 3'd1, 3'd1, 8'h00, 1'b1, 1'b0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_pipe_exec.md
Name: alu_pipe_exec

Overview:
- Parametrised, pipelined decode-and-execute unit.
- Architectural register file of NREG×WIDTH registers.
- Instructions enter as {op, rd, rs, rt} over a valid/ready handshake, execute one of 8 ALU ops, write back to rd, and emit the result plus flags over a second valid/ready handshake.
- Sits between the instruction sequencer and the board display/result logic.

Parameters:
- WIDTH, 8, datapath/register width in bits (≥4).
- NREG, 8, number of registers (power of 2, ≥2); AW = $clog2(NREG) is derived locally.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  unit can accept an instruction.
- in_op  input  3  opcode.
- in_rd  input  AW  destination register index.
- in_rs  input  AW  source register index.
- in_rt  input  AW  source register index.
- cfg_we  input  1  host register write strobe.
- cfg_addr  input  AW  host write index.
- cfg_data  input  WIDTH  host write data.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result value.
- out_rd  output  AW  destination index of the result.
- out_zero  output  1  out_data == 0.
- out_ovf  output  1  signed overflow (ADD/SUB only, else 0).

Behaviour:
- Reset (async, rst_n=0): all registers = 0, S1/S2 valid = 0, out_data/out_rd/out_zero/out_ovf = 0, out_valid = 0. in_ready = 1 on the first clk edge after release.
- Pipeline:
  - S1 (issue) holds op and indices.
  - S2 (result) holds data, rd and flags.
- Accept: in_valid && in_ready at an edge loads S1.
- in_ready = !s1_valid || s1_adv.
- s1_adv = s1_valid && !cfg_we && (!s2_valid || out_ready).
- Execute: on s1_adv, operands are read combinationally from the register file. At that edge the result is loaded into S2 AND written into register rd. Operands are therefore always current, so no bypass is needed.
- Latency: accepted at edge N gives out_valid at edge N+1 (no stall). Throughput is 1 instruction/cycle while out_ready=1.
- S2 clear: out_valid && out_ready with no s1_adv in the same cycle clears S2. Simultaneous consume and advance reloads S2.
- Backpressure: out_valid=0 → out_data/out_rd/flags hold their last values. out_valid=1 && out_ready=0 → all out_* held stable.
- cfg_we has priority over execute: the register is written at the edge, and S1 stalls that cycle.
  - cfg_we while S1/S2 are idle is a plain write.
  - rd written by execute and cfg in different cycles: last write wins.
- Opcodes (rs=A, rt=B, all results WIDTH bits, mod 2^WIDTH):
  - 0 SUB: A−B. ovf = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - 1 ADD: A+B. ovf = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - 2 OR: A|B.
  - 3 AND: A&B.
  - 4 SRA: B arithmetic right shift by 1 (msb replicated).
  - 5 ROL: A rotate left by 1.
  - 6 LT: {0…, A<B unsigned}.
  - 7 EQ: {0…, A==B}.
- out_zero is computed from the result for every op.
- Indices: rd may equal rs/rt. Operands are read before the write at the same edge.
- Reset mid-operation: in-flight S1/S2 contents are discarded and registers are cleared. No partial writeback.

Optional Feature:
- Macro ALU_PIPE_SEVSEG_EN.
- Defined:
  - Adds outputs seg[6:0] (active-low segments a..g, seg[0]=a) and an[3:0] = 4'b1110.
  - seg shows hex 0–F of a display register holding out_data[3:0], updated on each out_valid&&out_ready.
  - Display register resets to 0, so seg shows "0" (7'b1000000).
- Undefined: ports and logic are absent. Core behaviour is identical.

Test Plan (WIDTH=8, NREG=8):
1. Reset: assert rst_n=0 mid-stream, check outputs. Required: out_valid=0, out_data=0x00, regs read 0. One cycle after release: in_ready=1.
2. Dependent back-to-back:
   - cfg r1=0x05, r2=0x03.
   - SUB r3,r1,r2 then ADD r4,r3,r1 on consecutive cycles, out_ready=1.
   - Required: outputs 0x02 (rd=3) then 0x07 (rd=4) on consecutive cycles.
3. Shift ops: r2=0x90, r1=0x81. SRA r5,_,r2 → 0xC8; ROL r6,r1,_ → 0x03.
4. Backpressure:
   - out_ready=0, issue 3 instructions.
   - Required: in_ready drops after 2 are held. out_data stays stable.
   - Release: all 3 results emerge in order, none lost or duplicated.
5. Flags:
   - 0x7F+0x01 → 0x80, ovf=1.
   - 0x00−0x01 → 0xFF, ovf=0.
   - SUB r,r (same reg) → 0x00, zero=1.
   - LT 0x00,0x01 → 0x01.
   - EQ 0x5A,0x5A → 0x01.
6. cfg conflict: cfg_we to r1 in the same cycle S1 is valid. Required: S1 stalls one cycle, then executes using the new r1 value.
